// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use/branch hazard stalls, redirect flushes and multi-cycle multiply hold for a 5-stage MIPS pipeline.
module hazard_stall_controller #(
  parameter int MULT_LATENCY = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       IFID_Rs,
  input  logic [4:0]       IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_Jr,
  input  logic             ID_MultStart,
  input  logic             BranchTaken,
  input  logic             Jump,
  input  logic [1:0]       IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_WriteReg,
  input  logic [1:0]       EXMEM_MemRead,
  input  logic [4:0]       EXMEM_WriteReg,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             controlMuxSignal,
  output logic             EXHold,
  output logic             EXMEMBubble,
  output logic             MultBusy,
  output logic [CNT_W-1:0] StallCycles
);
  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] MULT_BUSY = 1'b1;
  logic [0:0]       r_state;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             w_busy;
  logic             w_idex_match;
  logic             w_exmem_match;
  logic             w_load_use;
  logic             w_br_haz;
  logic             w_stall;
  logic             w_run_ok;
  function automatic logic f_match(input logic [4:0] r, input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction
  always_comb begin
    w_busy           = (r_state == MULT_BUSY);
    w_idex_match     = f_match(IDEX_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);
    w_exmem_match    = f_match(EXMEM_WriteReg, IFID_Rs, IFID_Rt, IFID_UsesRt);
    w_load_use       = (IDEX_MemRead != 2'd0) && w_idex_match;
    w_br_haz         = (ID_Branch || ID_Jr) && ((IDEX_RegWrite && w_idex_match) || ((EXMEM_MemRead != 2'd0) && w_exmem_match));
    w_stall          = w_load_use || w_br_haz;
    w_run_ok         = !w_busy && !w_stall;
    // Reset forces idle values regardless of the state still held in the registers
    PCWrite          = Reset || w_run_ok;
    IFIDWrite        = Reset || w_run_ok;
    controlMuxSignal = Reset || w_busy || !w_stall;
    IFIDFlush        = !Reset && w_run_ok && (BranchTaken || Jump);
    EXHold           = !Reset && w_busy;
    EXMEMBubble      = !Reset && w_busy;
    MultBusy         = w_busy;
    StallCycles      = r_stall_cycles;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= RUN;
      r_cnt          <= 4'd0;
      r_stall_cycles <= '0;
    end else begin
      if (w_busy) begin
        r_state <= (r_cnt == 4'd1) ? RUN : MULT_BUSY;
        r_cnt   <= r_cnt - 4'd1;
      end else if (!w_stall && ID_MultStart) begin
        r_state <= MULT_BUSY;
        r_cnt   <= 4'(MULT_LATENCY - 1);
      end
      if (!PCWrite && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard and stall sequencer for the 5-stage MIPS datapath.
- Drives the bubble-select input of the ID-stage control mux (1 = pass decoded controls, 0 = zero them).
- Drives the PC and IF/ID write enables, the IF/ID flush, and the EX hold.
- Handles load-use and branch-operand hazards, taken-branch/jump flushes, and multi-cycle multiply occupancy of EX. Keeps a saturating stall-cycle counter.

Parameters:
MULT_LATENCY, 4, total cycles a multiply occupies EX (legal range 2..15)
CNT_W, 16, width of the StallCycles performance counter

Ports:
Clk  input  1  pipeline clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
IFID_Rs  input  5  rs field of instruction in ID
IFID_Rt  input  5  rt field of instruction in ID
IFID_UsesRt  input  1  instruction in ID reads rt as a source
ID_Branch  input  1  ID instruction is a conditional branch compared in ID
ID_Jr  input  1  ID instruction is jr (reads rs in ID)
ID_MultStart  input  1  ID instruction is a multi-cycle multiply
BranchTaken  input  1  branch in ID resolved taken this cycle
Jump  input  1  j/jal/jr redirect from ID this cycle
IDEX_MemRead  input  2  MemRead of instruction in EX (nonzero = load)
IDEX_RegWrite  input  1  instruction in EX writes a register
IDEX_WriteReg  input  5  destination register of instruction in EX
EXMEM_MemRead  input  2  MemRead of instruction in MEM
EXMEM_WriteReg  input  5  destination register of instruction in MEM
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register write enable
IFIDFlush  output  1  zero IF/ID on next edge
controlMuxSignal  output  1  control mux select, 0 inserts bubble into ID/EX
EXHold  output  1  hold ID/EX and EX-stage multiplier operands
EXMEMBubble  output  1  load zeroed controls into EX/MEM
MultBusy  output  1  state == MULT_BUSY
StallCycles  output  CNT_W  count of cycles with PCWrite = 0

Behaviour:
- State register: RUN, MULT_BUSY. Down-counter cnt is 4 bits.
- Reset (sampled high at edge): state=RUN, cnt=0, StallCycles=0.
- While Reset is high, outputs take idle values: PCWrite=1, IFIDWrite=1, controlMuxSignal=1, IFIDFlush=0, EXHold=0, EXMEMBubble=0.
- Reset mid-multiply aborts it; the next cycle is RUN.
- Match rule: a register r matches when r != 0 and (r == IFID_Rs or (IFID_UsesRt and r == IFID_Rt)).
- loadUse = IDEX_MemRead != 0 and IDEX_WriteReg matches.
- brHaz = (ID_Branch or ID_Jr) and one of:
  - IDEX_RegWrite and IDEX_WriteReg matches, or
  - EXMEM_MemRead != 0 and EXMEM_WriteReg matches.
- stall = loadUse or brHaz. This is combinational, same cycle, with no added latency.
- RUN, stall=1:
  - PCWrite=0, IFIDWrite=0, controlMuxSignal=0, IFIDFlush=0.
  - BranchTaken and Jump are ignored; the branch is unresolved and re-evaluates next cycle.
  - ID_MultStart is ignored.
- RUN, stall=0:
  - PCWrite=1, IFIDWrite=1, controlMuxSignal=1.
  - IFIDFlush = BranchTaken or Jump.
  - If ID_MultStart=1: next state = MULT_BUSY, cnt = MULT_LATENCY-1.
  - A multiply is not itself a branch; if both are flagged, the flush still applies and the multiply still starts.
- MULT_BUSY:
  - PCWrite=0, IFIDWrite=0, EXHold=1, EXMEMBubble=1, controlMuxSignal=1 (ID/EX is held, not bubbled).
  - IFIDFlush=0. Hazard, branch and jump inputs are ignored.
  - cnt decrements each cycle. When cnt == 1 at an edge, next state is RUN (cnt → 0).
  - Net: exactly MULT_LATENCY-1 busy cycles after the issue cycle.
- In the first RUN cycle after MULT_BUSY, EXMEMBubble=0, so the multiply result enters EX/MEM.
- Back-to-back multiplies re-enter MULT_BUSY with no extra gap.
- StallCycles increments by 1 on every non-reset edge where PCWrite=0. It saturates at 2^CNT_W-1 (no wrap).

Test Plan:
- lw $5 in EX (IDEX_MemRead=1, IDEX_WriteReg=5), add $6,$5,$2 in ID → exactly 1 cycle with PCWrite=0, IFIDWrite=0, controlMuxSignal=0; next cycle all 1; StallCycles=1.
- lw to $0 followed by a use of $0 → no stall; IDEX_WriteReg=3 with IFID_Rt=3 and IFID_UsesRt=0 → no stall.
- beq $4 with addi $4 in EX → 1 stall. beq $4 with lw $4 in EX → 2 stall cycles (EX, then MEM); after that BranchTaken=1 gives IFIDFlush=1 for one cycle.
- BranchTaken=1 with stall=0 → IFIDFlush=1, PCWrite=1. BranchTaken=1 with stall=1 → IFIDFlush=0.
- ID_MultStart, MULT_LATENCY=4 → MultBusy=1 for 3 cycles; EXHold and EXMEMBubble high for those 3 cycles; PCWrite=0 for 3 cycles; StallCycles += 3. Repeat with back-to-back multiplies.
- Reset asserted in the 2nd MULT_BUSY cycle → next cycle RUN, outputs idle, StallCycles=0.
- Force StallCycles to near saturation (CNT_W=4, 20 stall cycles) → StallCycles holds at 15.
